// File: rtl/sq_poly_pkg.sv
// Shared parameters, types and coefficient arithmetic for the serial R_q multiplier.
// Default ring is NTRU-HRSS: N=701 coefficients, modulus 2^13.
package sq_poly_pkg;

    localparam int N = 701;
    localparam int W = 13;

    typedef logic [W-1:0] coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } stream_state_t;

    // Multiply-accumulate with the natural 2^W wrap of W-bit arithmetic.
    function automatic coeff_t coeff_mac(input coeff_t acc, input coeff_t a, input coeff_t b);
        return coeff_t'(acc + a * b);
    endfunction

endpackage

// File: rtl/sq_coeff_stream.sv
// Captures operand t and streams its coefficients highest index first, one per cycle.
// Latency: first coefficient valid the cycle after the accepting edge; N coefficients; done pulses after the last.
// Backpressure: none; load is ignored while streaming and accepted when idle or on the done cycle.
module sq_coeff_stream #(
    parameter int N = sq_poly_pkg::N,
    parameter int W = sq_poly_pkg::W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [N*W-1:0] t,
    output logic [W-1:0]   c,
    output logic           accept,
    output logic           busy,
    output logic           done
);
    import sq_poly_pkg::*;

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    stream_state_t  state;
    stream_state_t  state_nxt;
    logic [N*W-1:0] t_reg;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_reg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            t_reg <= t;
            cnt   <= CW'(N - 1);
        end else if (state == ST_RUN && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign c    = busy ? t_reg[W*cnt +: W] : '0;

endmodule

// File: rtl/sq_poly_mult_serial.sv
// Serial Horner multiplier in Z_{2^W}[x]/(x^N-1): acc <= x*acc + c*h per streamed coefficient of t.
// Latency: N update edges after the load edge; done pulses one cycle with e = t*h, e_sq its reduction mod Phi_N.
// Backpressure: none; load while busy is dropped, load on the done cycle starts the next product.
module sq_poly_mult_serial #(
    parameter int N = sq_poly_pkg::N,
    parameter int W = sq_poly_pkg::W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [N*W-1:0]     t,
    input  logic [(N-1)*W-1:0] h,
    output logic [W-1:0]       c,
    output logic [N*W-1:0]     e,
    output logic [N*W-1:0]     e_next,
    output logic [(N-1)*W-1:0] e_sq,
    output logic               busy,
    output logic               done
);
    import sq_poly_pkg::*;

    logic                   accept;
    logic [(N-1)*W-1:0]     h_reg;

    sq_coeff_stream #(
        .N (N),
        .W (W)
    ) u_stream (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .t      (t),
        .c      (c),
        .accept (accept),
        .busy   (busy),
        .done   (done)
    );

    // Lane j takes the rotated neighbour (x*acc) and adds c*h_j; h_{N-1} is implicitly zero.
    for (genvar j = 0; j < N; j++) begin : gen_lane
        localparam int JP = (j == 0) ? N - 1 : j - 1;
        logic [W-1:0] h_j;
        if (j < N - 1) begin : gen_h
            assign h_j = h_reg[W*j +: W];
        end else begin : gen_h_top
            assign h_j = '0;
        end
        assign e_next[W*j +: W] = coeff_mac(e[W*JP +: W], c, h_j);
    end

    for (genvar j = 0; j < N - 1; j++) begin : gen_sq
        assign e_sq[W*j +: W] = e[W*j +: W] - e[W*(N-1) +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e     <= '0;
            h_reg <= '0;
        end else if (accept) begin
            e     <= '0;
            h_reg <= h;
        end else if (busy) begin
            e <= e_next;
        end
    end

endmodule

// File: tb/tb_sq_poly_mult_serial.sv
// Self-checking bench: hand-derived N=5 vector table, multi-cycle corner sequences,
// and random N=5 / N=701 operands against a schoolbook cyclic-convolution model.
module tb_sq_poly_mult_serial;

    localparam int W  = 13;
    localparam int NS = 5;
    localparam int NB = 701;
    localparam int MASK = (1 << W) - 1;

    typedef int coef_arr_t [NB];

    typedef struct {
        int t  [NS];
        int h  [NS-1];
        int ee [NS];
        int es [NS-1];
        int cs [NS];
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 load5;
    logic [NS*W-1:0]      t5;
    logic [(NS-1)*W-1:0]  h5;
    logic [W-1:0]         c5;
    logic [NS*W-1:0]      e5;
    logic [NS*W-1:0]      en5;
    logic [(NS-1)*W-1:0]  esq5;
    logic                 busy5;
    logic                 done5;

    logic                 loadb;
    logic [NB*W-1:0]      tb_t;
    logic [(NB-1)*W-1:0]  tb_h;
    logic [W-1:0]         cb;
    logic [NB*W-1:0]      eb;
    logic [NB*W-1:0]      enb;
    logic [(NB-1)*W-1:0]  esqb;
    logic                 busyb;
    logic                 doneb;

    sq_poly_mult_serial #(.N(NS), .W(W)) dut5 (
        .clk(clk), .rst_n(rst_n), .load(load5), .t(t5), .h(h5), .c(c5),
        .e(e5), .e_next(en5), .e_sq(esq5), .busy(busy5), .done(done5)
    );

    sq_poly_mult_serial #(.N(NB), .W(W)) dutb (
        .clk(clk), .rst_n(rst_n), .load(loadb), .t(tb_t), .h(tb_h), .c(cb),
        .e(eb), .e_next(enb), .e_sq(esqb), .busy(busyb), .done(doneb)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] ref_v);
        n_vec++;
        if (act !== ref_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, ref_v);
        end
    endtask

    task automatic chk_big(input string name, input int ncoef, input logic [NB*W-1:0] act,
                           input logic [NB*W-1:0] ref_v);
        int bad;
        bad = -1;
        n_vec++;
        for (int i = ncoef - 1; i >= 0; i--) begin
            if (act[W*i +: W] !== ref_v[W*i +: W]) bad = i;
        end
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: coeff %0d got %0d expected %0d", name, bad,
                     act[W*bad +: W], ref_v[W*bad +: W]);
        end
    endtask

    function automatic logic [NB*W-1:0] pack(input coef_arr_t a, input int n);
        logic [NB*W-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[W*i +: W] = W'(a[i]);
        return v;
    endfunction

    // Schoolbook product: t_i*h_j lands on x^((i+j) mod n); h_{n-1} is zero.
    function automatic void conv(input int n, input coef_arr_t ta, input coef_arr_t ha,
                                 output coef_arr_t ea);
        for (int k = 0; k < NB; k++) ea[k] = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1; j++)
                ea[(i + j) % n] = (ea[(i + j) % n] + ta[i] * ha[j]) & MASK;
    endfunction

    function automatic void reduce_sq(input int n, input coef_arr_t ea, output coef_arr_t sa);
        for (int k = 0; k < NB; k++) sa[k] = 0;
        for (int i = 0; i < n - 1; i++) sa[i] = (ea[i] - ea[n-1]) & MASK;
    endfunction

    task automatic load5_op(input logic [NS*W-1:0] tv, input logic [(NS-1)*W-1:0] hv);
        @(negedge clk);
        load5 = 1'b1;
        t5    = tv;
        h5    = hv;
        @(posedge clk);
        #1;
        load5 = 1'b0;
        for (int i = 0; i < NS; i++)     t5[W*i +: W] = W'($urandom);
        for (int i = 0; i < NS - 1; i++) h5[W*i +: W] = W'($urandom);
    endtask

    task automatic wait_done5(output int cyc, output int cs [NS]);
        cyc = 0;
        for (int i = 0; i < NS; i++) cs[i] = -1;
        for (int k = 1; k <= NS + 4; k++) begin
            if (k <= NS) cs[k-1] = int'(c5);
            @(posedge clk);
            #1;
            if (done5) begin
                cyc = k;
                break;
            end
        end
    endtask

    vec_t            vecs [5];
    logic [127:0]    exp_v;
    logic [127:0]    act_v;
    logic [NB*W-1:0] big;
    int              cyc;
    int              cs [NS];
    int              seen_done;
    coef_arr_t       ta, ha, ea, sa;
    logic [NS*W-1:0]     ta5, tb5, ea5, eb5;
    logic [(NS-1)*W-1:0] ha5, hb5, sb5;

    initial begin
        rst_n = 1'b0;
        load5 = 1'b0; t5 = '0; h5 = '0;
        loadb = 1'b0; tb_t = '0; tb_h = '0;

        vecs[0] = '{'{1,0,0,0,0}, '{3,5,7,9}, '{3,5,7,9,0}, '{3,5,7,9}, '{0,0,0,0,1}};
        vecs[1] = '{'{0,1,0,0,0}, '{3,5,7,9}, '{0,3,5,7,9}, '{8183,8186,8188,8190}, '{0,0,0,1,0}};
        vecs[2] = '{'{2,0,0,0,0}, '{8191,8191,8191,8191}, '{8190,8190,8190,8190,0},
                    '{8190,8190,8190,8190}, '{0,0,0,0,2}};
        vecs[3] = '{'{1,2,0,0,0}, '{1,1,0,0}, '{1,3,2,0,0}, '{1,3,2,0}, '{0,0,0,2,1}};
        vecs[4] = '{'{0,0,0,0,1}, '{1,2,3,4}, '{2,3,4,0,1}, '{1,2,3,8191}, '{1,0,0,0,0}};

        #12;
        chk("rst_busy5", 128'(busy5), 128'(0));
        chk("rst_done5", 128'(done5), 128'(0));
        chk("rst_e5",    128'(e5),    128'(0));
        chk("rst_c5",    128'(c5),    128'(0));
        chk("rst_esq5",  128'(esq5),  128'(0));
        chk("rst_busyb", 128'(busyb), 128'(0));
        chk_big("rst_eb", NB, eb, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-derived table.
        for (int v = 0; v < 5; v++) begin
            ta5 = '0; ha5 = '0;
            for (int i = 0; i < NS; i++)     ta5[W*i +: W] = W'(vecs[v].t[i]);
            for (int i = 0; i < NS - 1; i++) ha5[W*i +: W] = W'(vecs[v].h[i]);
            load5_op(ta5, ha5);
            chk($sformatf("busy_v%0d", v), 128'(busy5), 128'(1));
            wait_done5(cyc, cs);
            chk($sformatf("lat_v%0d", v), 128'(cyc), 128'(NS));
            exp_v = '0;
            for (int i = 0; i < NS; i++) exp_v[W*i +: W] = W'(vecs[v].ee[i]);
            chk($sformatf("e_v%0d", v), 128'(e5), exp_v);
            exp_v = '0;
            for (int i = 0; i < NS - 1; i++) exp_v[W*i +: W] = W'(vecs[v].es[i]);
            chk($sformatf("esq_v%0d", v), 128'(esq5), exp_v);
            exp_v = '0; act_v = '0;
            for (int i = 0; i < NS; i++) begin
                exp_v[16*i +: 16] = 16'(vecs[v].cs[i]);
                act_v[16*i +: 16] = 16'(cs[i]);
            end
            chk($sformatf("cseq_v%0d", v), act_v, exp_v);
            @(posedge clk);
            #1;
            chk($sformatf("done_drop_v%0d", v), 128'(done5), 128'(0));
            exp_v = '0;
            for (int i = 0; i < NS; i++) exp_v[W*i +: W] = W'(vecs[v].ee[i]);
            chk($sformatf("e_hold_v%0d", v), 128'(e5), exp_v);
        end

        // Random N=5 operands against the model.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NB; k++) begin ta[k] = 0; ha[k] = 0; end
            for (int i = 0; i < NS; i++)     ta[i] = int'($urandom_range(0, MASK));
            for (int i = 0; i < NS - 1; i++) ha[i] = int'($urandom_range(0, MASK));
            conv(NS, ta, ha, ea);
            reduce_sq(NS, ea, sa);
            big = pack(ta, NS); ta5 = big[NS*W-1:0];
            big = pack(ha, NS - 1); ha5 = big[(NS-1)*W-1:0];
            load5_op(ta5, ha5);
            wait_done5(cyc, cs);
            chk($sformatf("lat_r%0d", r), 128'(cyc), 128'(NS));
            big = pack(ea, NS);
            chk($sformatf("e_r%0d", r), 128'(e5), 128'(big[NS*W-1:0]));
            big = pack(sa, NS - 1);
            chk($sformatf("esq_r%0d", r), 128'(esq5), 128'(big[(NS-1)*W-1:0]));
        end

        // Load while busy is ignored; load on the done cycle is accepted.
        ta5 = '0; ta5[W-1:0] = W'(1);
        ha5 = {W'(9), W'(7), W'(5), W'(3)};
        ea5 = {W'(0), W'(9), W'(7), W'(5), W'(3)};
        for (int k = 0; k < NB; k++) begin ta[k] = 0; ha[k] = 0; end
        for (int i = 0; i < NS; i++)     ta[i] = int'($urandom_range(0, MASK));
        for (int i = 0; i < NS - 1; i++) ha[i] = int'($urandom_range(0, MASK));
        conv(NS, ta, ha, ea);
        reduce_sq(NS, ea, sa);
        big = pack(ta, NS);     tb5 = big[NS*W-1:0];
        big = pack(ha, NS - 1); hb5 = big[(NS-1)*W-1:0];
        big = pack(ea, NS);     eb5 = big[NS*W-1:0];
        big = pack(sa, NS - 1); sb5 = big[(NS-1)*W-1:0];

        load5_op(ta5, ha5);
        @(posedge clk);
        #1;
        @(negedge clk);
        load5 = 1'b1; t5 = tb5; h5 = hb5;
        @(posedge clk);
        #1;
        load5 = 1'b0;
        chk("busy_ign", 128'(busy5), 128'(1));
        cyc = 0;
        for (int k = 3; k <= NS + 4; k++) begin
            @(posedge clk);
            #1;
            if (done5) begin
                cyc = k;
                break;
            end
        end
        chk("lat_ign", 128'(cyc), 128'(NS));
        chk("e_ign", 128'(e5), 128'(ea5));
        load5 = 1'b1; t5 = tb5; h5 = hb5;
        @(posedge clk);
        #1;
        load5 = 1'b0;
        chk("done_b2b", 128'(done5), 128'(0));
        chk("busy_b2b", 128'(busy5), 128'(1));
        wait_done5(cyc, cs);
        chk("lat_b2b", 128'(cyc), 128'(NS));
        chk("e_b2b", 128'(e5), 128'(eb5));
        chk("esq_b2b", 128'(esq5), 128'(sb5));

        // Reset in the middle of streaming aborts without a done pulse.
        load5_op(tb5, hb5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy5), 128'(0));
        chk("abort_e", 128'(e5), 128'(0));
        chk("abort_c", 128'(c5), 128'(0));
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done5) seen_done++;
        end
        chk("abort_nodone", 128'(seen_done), 128'(0));
        load5_op(ta5, ha5);
        wait_done5(cyc, cs);
        chk("lat_post", 128'(cyc), 128'(NS));
        chk("e_post", 128'(e5), 128'(ea5));

        // Full-size ring.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NB; i++)     ta[i] = int'($urandom_range(0, MASK));
            for (int i = 0; i < NB; i++)     ha[i] = 0;
            for (int i = 0; i < NB - 1; i++) ha[i] = int'($urandom_range(0, MASK));
            conv(NB, ta, ha, ea);
            reduce_sq(NB, ea, sa);
            @(negedge clk);
            loadb = 1'b1;
            tb_t  = pack(ta, NB);
            big   = pack(ha, NB - 1);
            tb_h  = big[(NB-1)*W-1:0];
            @(posedge clk);
            #1;
            loadb = 1'b0;
            tb_t  = '0;
            cyc = 0;
            for (int k = 1; k <= NB + 8; k++) begin
                @(posedge clk);
                #1;
                if (doneb) begin
                    cyc = k;
                    break;
                end
            end
            chk($sformatf("lat_big%0d", r), 128'(cyc), 128'(NB));
            chk_big($sformatf("e_big%0d", r), NB, eb, pack(ea, NB));
            chk_big($sformatf("esq_big%0d", r), NB - 1, {{W{1'b0}}, esqb}, pack(sa, NB - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sq_poly_mult_serial.md
Name: sq_poly_mult_serial

Overview:
- Serial multiplier in R_q = Z_q[x]/(x^N − 1), q = 2^W; default N=701, W=13 (NTRU-HRSS).
- Operand t is captured, then streamed one coefficient per cycle, highest index first.
- Each streamed coefficient drives a Horner update: acc ← x·acc + c·h.
- After N updates it presents the product in R_q, plus its reduction into S_q (mod Φ_N), for the KEM arithmetic datapath.

Parameters:
- N, 701, number of polynomial coefficients (ring degree).
- W, 13, coefficient width; arithmetic is modulo 2^W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  start request; sampled on clk rising edge
- t  in  N*W  multiplicand; coefficient i at t[W*i +: W]
- h  in  (N−1)*W  multiplier in S_q; coefficient i at h[W*i +: W]; h_{N−1} treated as 0
- c  out  W  coefficient of t currently streamed
- e  out  N*W  accumulator / final product in R_q
- e_next  out  N*W  combinational next accumulator value
- e_sq  out  (N−1)*W  S_q reduction of e: e_sq_i = e_i − e_{N−1} mod 2^W
- busy  out  1  high while streaming
- done  out  1  one-cycle pulse when e holds the final product

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, done=0, cnt=0.
  - e, captured t_reg and h_reg all cleared to 0; c therefore reads 0.
- Idle (busy=0), load=1 at a rising edge:
  - t_reg←t, h_reg←h, e←0, cnt←N−1, busy←1, done←0.
- c = t_reg coefficient [cnt] while busy; 0 when idle.
- e_next (combinational, always driven):
  - e_next_j = e_{(j−1) mod N} + c·h_reg_j, mod 2^W.
  - h_reg_{N−1}=0; products truncated to W bits; all sums wrap.
- Busy, each rising edge:
  - e←e_next.
  - If cnt=0: busy←0, done←1 for exactly the next cycle. Otherwise cnt←cnt−1.
- Latency:
  - load sampled at edge k; N update edges k+1..k+N.
  - done high in the cycle after edge k+N.
  - e = t·h mod (x^N−1, 2^W) from then on.
- e and e_sq hold their value until the next accepted load or reset.
- load while busy is ignored; the operation in flight completes unchanged.
- load in the same cycle as done is accepted; done drops and the new operation starts.
- t and h may change after the capture edge without effect.
- rst_n asserted mid-operation aborts immediately to reset state; no done pulse.
- e_sq is purely combinational from e.

Decomposition:
- Package sq_poly_pkg:
  - localparams N, W.
  - typedef coeff_t = logic [W-1:0].
  - function coeff_mac(acc, a, b) returning (acc + a·b) mod 2^W.
- Sub-module sq_coeff_stream:
  - holds t_reg, cnt, busy, done; outputs c.
  - mirrors the coefficient-generator role.
- Top level holds h_reg, e, the N parallel MAC lanes and the e_sq subtractors.

Test Plan:
- N=5, W=13; t=1 (c_0=1), h=[3,5,7,9] → e=[3,5,7,9,0]; e_sq=[3,5,7,9]; done exactly 5 cycles after load edge.
- N=5; t=x (c_1=1), h=[3,5,7,9] → e=[0,3,5,7,9]; e_sq=[8183,8186,8188,8190]. Checks rotation and S_q subtraction wrap.
- N=5; t=2, h all 8191 → e=[8190,8190,8190,8190,0]. Checks mod 2^13 wrap; c stream observed as 0,0,0,0,2.
- N=5; load again while busy with a different t → ignored; result equals the first operation. Then load on the done cycle → second operation starts, correct result N cycles later.
- rst_n low at cycle 2 of streaming → busy=0, e=0, no done pulse. Subsequent load produces the correct product.
- N=701, W=13: 20 random t, h vectors vs a schoolbook cyclic-convolution model; e and e_sq exact match, done at cycle 701.
